// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the OV7670-class camera capture stage:
//   - default stored frame geometry (QQVGA 160x120) and pixel count
//   - capture FSM state encoding
//   - RGB444 nibble field positions inside a packed pixel
//   - colour-bar constants and a selector for the optional test pattern
// -----------------------------------------------------------------------------
package cam_pkg;

    // Stored frame geometry. Address NPIX itself is never written by the
    // capture stage; the display side reads it as the black pixel.
    localparam int IMG_W_DEFAULT = 160;
    localparam int IMG_H_DEFAULT = 120;
    localparam int NPIX          = IMG_W_DEFAULT * IMG_H_DEFAULT;

    // Capture FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_SYNC    = 2'd2,
        ST_CAPTURE = 2'd3
    } cam_state_t;

    // RGB444 layout: {R[3:0], G[3:0], B[3:0]}.
    localparam int NIB   = 4;
    localparam int R_LSB = 8;
    localparam int G_LSB = 4;
    localparam int B_LSB = 0;

    // Vertical colour bars, 32 columns wide each.
    localparam logic [11:0] COL_WHITE   = 12'hFFF;
    localparam logic [11:0] COL_YELLOW  = 12'hFF0;
    localparam logic [11:0] COL_CYAN    = 12'h0FF;
    localparam logic [11:0] COL_GREEN   = 12'h0F0;
    localparam logic [11:0] COL_MAGENTA = 12'hF0F;
    localparam logic [11:0] COL_BLACK   = 12'h000;

    // Colour of bar number idx (column / 32). Only 0..4 occur for a
    // 160-pixel line; anything beyond falls back to black.
    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// -----------------------------------------------------------------------------
// cam_sync_edge
// Input register stage for the camera pins plus edge pulses.
// Everything downstream works from the registered copies so that the byte,
// HREF and VSYNC seen by the packer are always mutually aligned.
//
// Ports:
//   pclk     in   camera pixel clock
//   rst_n    in   asynchronous reset, active low
//   vsync    in   camera VSYNC pin
//   href     in   camera HREF pin
//   px_data  in   camera data byte
//   vs_q     out  registered VSYNC
//   hr_q     out  registered HREF
//   px_q     out  registered data byte
//   vs_rise  out  high for one cycle when vs_q goes 0->1
//   hr_fall  out  high for one cycle when hr_q goes 1->0
// -----------------------------------------------------------------------------
module cam_sync_edge (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       href,
    input  logic [7:0] px_data,
    output logic       vs_q,
    output logic       hr_q,
    output logic [7:0] px_q,
    output logic       vs_rise,
    output logic       hr_fall
);

    // Second stage holds the previous registered level for edge detection.
    logic vs_qq;
    logic hr_qq;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q  <= 1'b0;
            hr_q  <= 1'b0;
            px_q  <= 8'h00;
            vs_qq <= 1'b0;
            hr_qq <= 1'b0;
        end else begin
            vs_q  <= vsync;
            hr_q  <= href;
            px_q  <= px_data;
            vs_qq <= vs_q;
            hr_qq <= hr_q;
        end
    end

    assign vs_rise = vs_q & ~vs_qq;
    assign hr_fall = hr_qq & ~hr_q;

endmodule

// File: rtl/cam_capture_rgb444.sv
// -----------------------------------------------------------------------------
// cam_capture_rgb444
// Capture stage between an OV7670-class camera and a dual-port frame buffer.
// Two consecutive camera bytes form one RGB444 pixel which is written to the
// buffer at row*IMG_W + col. Only whole frames are captured: after enabling,
// the block waits for a complete VSYNC high->low sequence before it starts.
//
// Optional feature (macro CAM_TEST_PATTERN_EN):
//   defined   -> data_in carries vertical colour bars selected by col[7:5];
//                camera bytes only pace the writes.
//   undefined -> data_in carries the packed camera pixel.
//
// Ports:
//   pclk        in   camera pixel clock (only clock)
//   rst_n       in   asynchronous reset, active low
//   cap_en      in   capture enable (level)
//   vsync       in   camera VSYNC, high = vertical blanking
//   href        in   camera HREF, high = valid line bytes
//   px_data     in   camera data byte
//   addr_in     out  buffer write address (holds when regwrite=0)
//   data_in     out  buffer write data {R,G,B} (holds when regwrite=0)
//   regwrite    out  buffer write enable, one cycle per pixel
//   frame_done  out  one-cycle pulse at the end of a captured frame
//   busy        out  high while capturing a frame
//   overflow    out  sticky: camera sent more pixels/lines than stored
// -----------------------------------------------------------------------------
module cam_capture_rgb444
    import cam_pkg::*;
#(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int IMG_H = IMG_H_DEFAULT
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          cap_en,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite,
    output logic          frame_done,
    output logic          busy,
    output logic          overflow
);

    // Column counter must be able to hold IMG_W itself (the "line full"
    // value) and row counter IMG_H, so both get one extra code point.
    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);

    // ------------------------------------------------------------------
    // Registered camera inputs and edge pulses
    // ------------------------------------------------------------------
    logic       vs_q;
    logic       hr_q;
    logic [7:0] px_q;
    logic       vs_rise;
    logic       hr_fall;

    cam_sync_edge u_sync_edge (
        .pclk    (pclk),
        .rst_n   (rst_n),
        .vsync   (vsync),
        .href    (href),
        .px_data (px_data),
        .vs_q    (vs_q),
        .hr_q    (hr_q),
        .px_q    (px_q),
        .vs_rise (vs_rise),
        .hr_fall (hr_fall)
    );

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    cam_state_t state_reg;
    cam_state_t state_next;
    logic       sync_start;   // SYNC -> CAPTURE this cycle
    logic       frame_end;    // CAPTURE ends this cycle

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sync_start = 1'b0;
        frame_end  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cap_en) begin
                    state_next = ST_WAIT_VS;
                end
            end
            // Waiting for blanking first guarantees we never join a frame
            // that is already streaming.
            ST_WAIT_VS: begin
                if (vs_q) begin
                    state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (!vs_q) begin
                    state_next = ST_CAPTURE;
                    sync_start = 1'b1;
                end
            end
            // cap_en is only consulted at frame end, so dropping it
            // mid-frame lets the current frame finish.
            ST_CAPTURE: begin
                if (vs_rise) begin
                    frame_end  = 1'b1;
                    state_next = cap_en ? ST_SYNC : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Byte packer, counters and buffer write port
    // ------------------------------------------------------------------
    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;
    logic [AW-1:0] row_base_reg;   // row * IMG_W, kept by accumulation
    logic          phase_reg;      // 0: expecting first byte of a pixel
    logic [3:0]    red_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] data_reg;
    logic          regwrite_reg;
    logic          frame_done_reg;
    logic          overflow_reg;

    logic          pack_en;
    logic          pix_in_range;
    logic [DW-1:0] pixel;

    // The cycle in which VSYNC rises closes the frame; a half-assembled
    // pixel still in flight at that moment is discarded.
    assign pack_en      = (state_reg == ST_CAPTURE) && !vs_rise;
    assign pix_in_range = (col_reg < CW'(IMG_W)) && (row_reg < RW'(IMG_H));

`ifdef CAM_TEST_PATTERN_EN
    // Bars are 32 columns wide: bar index is the column divided by 32.
    always_comb begin
        pixel = DW'(bar_colour(3'(col_reg >> 5)));
    end
`else
    // Byte 0 carries red in its low nibble, byte 1 carries {G,B}.
    always_comb begin
        pixel                = '0;
        pixel[R_LSB +: NIB]  = red_reg;
        pixel[G_LSB +: NIB]  = px_q[7:4];
        pixel[B_LSB +: NIB]  = px_q[3:0];
    end
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg        <= '0;
            row_reg        <= '0;
            row_base_reg   <= '0;
            phase_reg      <= 1'b0;
            red_reg        <= 4'h0;
            addr_reg       <= '0;
            data_reg       <= '0;
            regwrite_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            regwrite_reg   <= 1'b0;
            frame_done_reg <= frame_end;

            if (sync_start) begin
                col_reg      <= '0;
                row_reg      <= '0;
                row_base_reg <= '0;
                phase_reg    <= 1'b0;
                overflow_reg <= 1'b0;
            end else if (pack_en) begin
                if (hr_q) begin
                    if (!phase_reg) begin
                        red_reg   <= px_q[3:0];
                        phase_reg <= 1'b1;
                    end else begin
                        phase_reg <= 1'b0;
                        if (pix_in_range) begin
                            regwrite_reg <= 1'b1;
                            addr_reg     <= row_base_reg + AW'(col_reg);
                            data_reg     <= pixel;
                            col_reg      <= col_reg + 1'b1;
                        end else begin
                            // col saturates at IMG_W and row at IMG_H,
                            // so every surplus pixel lands here.
                            overflow_reg <= 1'b1;
                        end
                    end
                end else if (hr_fall) begin
                    // A line without a single complete pixel does not
                    // advance the row. Row stops at IMG_H so row_base
                    // can never wrap into valid addresses.
                    if ((col_reg != '0) && (row_reg < RW'(IMG_H))) begin
                        row_reg      <= row_reg + 1'b1;
                        row_base_reg <= row_base_reg + AW'(IMG_W);
                    end
                    col_reg   <= '0;
                    phase_reg <= 1'b0;
                end
            end
        end
    end

    assign addr_in    = addr_reg;
    assign data_in    = data_reg;
    assign regwrite   = regwrite_reg;
    assign frame_done = frame_done_reg;
    assign overflow   = overflow_reg;
    assign busy       = (state_reg == ST_CAPTURE);

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// -----------------------------------------------------------------------------
// tb_cam_capture_rgb444
// Drives camera frames (constant, position-coded and random bytes) into
// cam_capture_rgb444. A frame model written from the pixel/line rules
// predicts every buffer write (cycle, address, data) and every frame_done
// pulse; a negedge process compares the DUT against it on every cycle.
// A few literal values pin the model. Prints one line per frame.
// -----------------------------------------------------------------------------
module tb_cam_capture_rgb444;

    localparam int AW    = 15;
    localparam int DW    = 12;
    localparam int IMG_W = 160;
    localparam int IMG_H = 120;
    localparam int NPIX  = IMG_W * IMG_H;

`ifdef CAM_TEST_PATTERN_EN
    localparam logic [11:0] BARS [5] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F};
    localparam logic [11:0] PX40_A   = 12'hFF0;
    localparam logic [11:0] PX517_B  = 12'hFF0;
`else
    localparam logic [11:0] PX40_A   = 12'hABC;
    localparam logic [11:0] PX517_B  = 12'h532;
`endif

    logic          pclk    = 1'b0;
    logic          rst_n   = 1'b0;
    logic          cap_en  = 1'b0;
    logic          vsync   = 1'b1;
    logic          href    = 1'b0;
    logic [7:0]    px_data = 8'h00;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          regwrite;
    logic          frame_done;
    logic          busy;
    logic          overflow;

    cam_capture_rgb444 #(
        .AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .cap_en     (cap_en),
        .vsync      (vsync),
        .href       (href),
        .px_data    (px_data),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .regwrite   (regwrite),
        .frame_done (frame_done),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct {
        int          cyc;
        int          addr;
        logic [11:0] data;
    } wr_t;

    wr_t         wq[$];
    int          fdq[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          wr_count = 0;
    int          fd_count = 0;
    int          wr_at_start = 0;
    int          fd_at_start = 0;
    bit          chk_on = 1'b0;
    bit          capturing = 1'b0;
    int          mrow = 0;
    bit          ovf_exp = 1'b0;
    logic [11:0] seen [NPIX];
    wr_t         cur_e;
    bit          exp_wr;
    bit          exp_fd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge pclk) begin
        if (chk_on && rst_n) begin
            exp_wr = (wq.size() > 0) && (wq[0].cyc == cyc);
            check("regwrite", 32'(regwrite), 32'(exp_wr));
            if (regwrite) begin
                wr_count++;
                if (int'(addr_in) < NPIX) seen[addr_in] = data_in;
            end
            if (exp_wr) begin
                cur_e = wq.pop_front();
                check("addr_in", 32'(addr_in), 32'(cur_e.addr));
                check("data_in", 32'(data_in), 32'(cur_e.data));
            end
            exp_fd = (fdq.size() > 0) && (fdq[0] == cyc);
            check("frame_done", 32'(frame_done), 32'(exp_fd));
            if (frame_done) fd_count++;
            if (exp_fd) void'(fdq.pop_front());
        end
    end

    // ---------------- stimulus + model ----------------
    task automatic drive(input logic h, input logic [7:0] b);
        @(posedge pclk);
        #1;
        href    = h;
        px_data = b;
    endtask

    task automatic reset_pulse();
        @(posedge pclk);
        #1;
        rst_n = 1'b0;
        // Writes/pulses not yet registered before reset never happen.
        while (wq.size() > 0 && wq[$].cyc >= cyc) void'(wq.pop_back());
        while (fdq.size() > 0 && fdq[$] >= cyc) void'(fdq.pop_back());
        #1;
        check("rst_mid_regwrite", 32'(regwrite), 32'd0);
        check("rst_mid_addr", 32'(addr_in), 32'd0);
        check("rst_mid_data", 32'(data_in), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_overflow", 32'(overflow), 32'd0);
        check("rst_mid_frame_done", 32'(frame_done), 32'd0);
        @(posedge pclk);
        #1;
        rst_n = 1'b1;
    endtask

    // mode 0: bytes 0A,BC   mode 1: (m[3:0], {n[3:0], m[7:4]})   mode 2: random
    task automatic send_line(input int n, input int npix, input bit extra,
                             input int mode, input int rst_at);
        logic [7:0] b0;
        logic [7:0] b1;
        wr_t        e;
        for (int m = 0; m < npix; m++) begin
            if (m == rst_at) begin
                reset_pulse();
                capturing = 1'b0;
            end
            case (mode)
                0: begin b0 = 8'h0A; b1 = 8'hBC; end
                1: begin b0 = {4'($urandom), 4'(m)}; b1 = {4'(n), 4'(m >> 4)}; end
                default: begin b0 = 8'($urandom); b1 = 8'($urandom); end
            endcase
            drive(1'b1, b0);
            drive(1'b1, b1);
            if (capturing) begin
                if (m < IMG_W && mrow < IMG_H) begin
                    e.cyc  = cyc + 2;
                    e.addr = mrow * IMG_W + m;
`ifdef CAM_TEST_PATTERN_EN
                    e.data = BARS[m / 32];
`else
                    e.data = {b0[3:0], b1};
`endif
                    wq.push_back(e);
                end else begin
                    ovf_exp = 1'b1;
                end
            end
        end
        if (extra) drive(1'b1, 8'($urandom));
        repeat (3) drive(1'b0, 8'h00);
        if (npix > 0) mrow++;
    endtask

    task automatic start_frame(input bit cap);
        capturing   = cap;
        mrow        = 0;
        ovf_exp     = 1'b0;
        wr_at_start = wr_count;
        fd_at_start = fd_count;
        @(posedge pclk);
        #1;
        vsync = 1'b0;
        repeat (4) @(posedge pclk);
        #1;
        if (cap) begin
            check("busy_in_frame", 32'(busy), 32'd1);
            check("overflow_at_start", 32'(overflow), 32'd0);
        end
    endtask

    task automatic end_frame(input string tag);
        @(posedge pclk);
        #1;
        vsync = 1'b1;
        if (capturing) fdq.push_back(cyc + 2);
        repeat (4) @(posedge pclk);
        #1;
        if (capturing) check("overflow_end", 32'(overflow), 32'(ovf_exp));
        $display("frame %s: writes=%0d frame_done=%0d overflow=%0b busy=%0b",
                 tag, wr_count - wr_at_start, fd_count - fd_at_start, overflow, busy);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        check("reset_regwrite", 32'(regwrite), 32'd0);
        check("reset_addr", 32'(addr_in), 32'd0);
        check("reset_data", 32'(data_in), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        cap_en = 1'b1;
        repeat (5) @(posedge pclk);

        // A: full frame of constant pixels
        start_frame(1'b1);
        for (int n = 0; n < IMG_H; n++) send_line(n, IMG_W, 1'b0, 0, -1);
        end_frame("A");
        check("A_write_count", 32'(wr_count - wr_at_start), 32'd19200);
        check("A_last_addr", 32'(addr_in), 32'd19199);
        check("A_pixel40", 32'(seen[40]), 32'(PX40_A));
        check("A_overflow", 32'(overflow), 32'd0);
        check("A_frame_done_count", 32'(fd_count - fd_at_start), 32'd1);

        // B: 162 pixels x 121 lines, position-coded bytes
        start_frame(1'b1);
        for (int n = 0; n < IMG_H + 1; n++) send_line(n, IMG_W + 2, 1'b0, 1, -1);
        end_frame("B");
        check("B_write_count", 32'(wr_count - wr_at_start), 32'd19200);
        check("B_last_addr", 32'(addr_in), 32'd19199);
        check("B_overflow", 32'(overflow), 32'd1);
        check("B_pixel517", 32'(seen[517]), 32'(PX517_B));

        // C: half pixel line, then random lines
        start_frame(1'b1);
        send_line(0, 1, 1'b1, 2, -1);
        check("C_half_pixel_writes", 32'(wr_count - wr_at_start), 32'd1);
        send_line(1, 2, 1'b0, 2, -1);
        for (int n = 2; n < 6; n++)
            send_line(n, int'($urandom_range(0, 60)), 1'($urandom_range(0, 1)), 2, -1);
        end_frame("C");

        // D: cap_en dropped mid-frame, frame still completes
        start_frame(1'b1);
        send_line(0, int'($urandom_range(1, 40)), 1'b0, 2, -1);
        cap_en = 1'b0;
        for (int n = 1; n < 4; n++)
            send_line(n, int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), 2, -1);
        end_frame("D");
        check("D_frame_done_count", 32'(fd_count - fd_at_start), 32'd1);
        check("D_busy_after", 32'(busy), 32'd0);

        // E: cap_en raised while vsync already low -> nothing captured
        start_frame(1'b0);
        send_line(0, 20, 1'b0, 2, -1);
        cap_en = 1'b1;
        send_line(1, 20, 1'b0, 2, -1);
        send_line(2, 20, 1'b0, 2, -1);
        end_frame("E");
        check("E_write_count", 32'(wr_count - wr_at_start), 32'd0);

        // F: first frame after arming
        start_frame(1'b1);
        send_line(0, int'($urandom_range(1, 50)), 1'b1, 2, -1);
        send_line(1, int'($urandom_range(1, 50)), 1'b0, 2, -1);
        end_frame("F");

        // G: reset pulse in the middle of line 1
        start_frame(1'b1);
        send_line(0, 10, 1'b0, 2, -1);
        send_line(1, 12, 1'b0, 2, 5);
        send_line(2, 8, 1'b0, 2, -1);
        end_frame("G");
        check("G_frame_done_count", 32'(fd_count - fd_at_start), 32'd0);

        // H: re-armed by G's closing vsync high and H's falling vsync
        start_frame(1'b1);
        send_line(0, 7, 1'b0, 2, -1);
        send_line(1, 9, 1'b0, 2, -1);
        end_frame("H");
        check("H_write_count", 32'(wr_count - wr_at_start), 32'd16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cam_capture_rgb444.md
Name: cam_capture_rgb444

Overview:
- Capture stage between the OV7670-class camera pins and the dual-port frame buffer.
- Samples the camera byte stream (VSYNC/HREF/8-bit data) on the camera pixel clock.
- Packs each pair of bytes into one RGB444 pixel and drives the buffer's write port (address, data, write enable).
- Frame size is fixed: 160x120 (QQVGA). Address IMG_W*IMG_H is never written; it is reserved for the black pixel.

Parameters:
- AW, 15: write address width.
- DW, 12: pixel width (RGB444).
- IMG_W, 160: pixels per line stored.
- IMG_H, 120: lines per frame stored.

Ports:
- pclk, input, 1: camera pixel clock; the only clock of the block.
- rst_n, input, 1: asynchronous reset, active low.
- cap_en, input, 1: capture enable (level).
- vsync, input, 1: camera VSYNC; high = vertical blanking.
- href, input, 1: camera HREF; high = valid line bytes.
- px_data, input, 8: camera data byte.
- addr_in, output, AW: buffer write address.
- data_in, output, DW: buffer write data {R,G,B}.
- regwrite, output, 1: buffer write enable, one pclk per pixel.
- frame_done, output, 1: one-cycle pulse at the end of a captured frame.
- busy, output, 1: high while in state CAPTURE.
- overflow, output, 1: sticky; set when the camera delivers more pixels or lines than IMG_W/IMG_H.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; addr_in=0, data_in=0, regwrite=0, frame_done=0, busy=0, overflow=0; all counters and input registers 0.
- Input stage: vsync, href, px_data registered once (vs_q, hr_q, px_q). Edges are detected from the registered versions.
- FSM:
  - IDLE: enter WAIT_VS when cap_en=1.
  - WAIT_VS: wait for vs_q=1, then go to SYNC. This means a frame already in progress is never captured partially.
  - SYNC: on vs_q=0, go to CAPTURE. Clear col, row, row_base, byte phase and overflow.
  - CAPTURE: on vs_q rising edge, pulse frame_done for 1 cycle, then go to SYNC if cap_en=1, else IDLE.
  - cap_en dropping mid-frame does not abort; the current frame completes.
- Byte packing (CAPTURE, hr_q=1):
  - Phase 0: hold red = px_q[3:0].
  - Phase 1: form pixel {red, px_q[7:4], px_q[3:0]}.
  - Phase toggles every byte while hr_q=1.
- Write timing:
  - regwrite=1 in the cycle after phase-1 byte registration, with addr_in = row_base + col and data_in = the pixel.
  - Latency from second byte on pins to regwrite high: 2 pclk edges.
  - regwrite is low in every other cycle. addr_in and data_in hold their last values when regwrite=0.
- Counters:
  - col increments after each pixel.
  - On hr_q falling edge: if col>0, row += 1 and row_base += IMG_W (adder only, no multiplier); col=0; phase=0.
- Boundaries:
  - col >= IMG_W, or row >= IMG_H: no write; overflow=1, held until the next SYNC→CAPTURE.
  - Odd byte count when href falls: half pixel dropped, no write.
  - href high outside CAPTURE: ignored.
  - Maximum address written is IMG_W*IMG_H-1 = 19199.
  - vsync rising with href still high: frame ends; the partial pixel is dropped.
- Reset asserted mid-frame: immediate return to IDLE. Re-arm requires a full vsync high→low sequence.

Optional Feature:
- Macro: CAM_TEST_PATTERN_EN.
- Defined: data_in is replaced by vertical colour bars chosen by col[7:5]: 0 white FFF, 1 yellow FF0, 2 cyan 0FF, 3 green 0F0, 4 magenta F0F. Timing, addresses, regwrite and all flags are unchanged; camera bytes only pace the writes.
- Undefined: data_in is the packed camera pixel.

Decomposition:
- Package cam_pkg:
  - IMG_W and IMG_H defaults.
  - NPIX = IMG_W*IMG_H.
  - FSM state encoding: IDLE, WAIT_VS, SYNC, CAPTURE (2-bit).
  - RGB444 nibble field positions.
  - Test-pattern colour constants.
- Sub-module cam_sync_edge: input register stage plus rise/fall pulse generation for vsync and href. The FSM and packer stay in the top module.

Test Plan:
- Reset, then cap_en=1, one frame of 120 lines × 160 pixels with bytes 0x0A,0xBC per pixel → 19200 writes, all data_in=ABC; addresses 0..19199 in order; one frame_done pulse; overflow=0.
- Line n, pixel m with bytes (m[3:0], {n[3:0],m[7:4]}) → write at address n*160+m, data checked against the model; second byte to regwrite = 2 edges.
- 162 pixels per line and 121 lines → no write beyond 19199; overflow=1 at frame end; next frame starts with overflow=0.
- href falls after 3 bytes (1.5 pixels) → 1 write only; next line starts at col 0, phase 0.
- cap_en raised mid-frame with vsync low → no writes until vsync high→low; cap_en dropped mid-frame → frame completes with frame_done, then IDLE, busy=0.
- rst_n pulsed low for 1 cycle mid-line → outputs 0 immediately; no writes until the next full vsync high→low sequence.
- With CAM_TEST_PATTERN_EN defined → pixel 40 of any line has data_in=FF0.
